entrada_pulsadores: RTL and testbench
=====================================

# entrada_pulsadores

Input conditioning stage that feeds the CPU's four 8-bit input ports (`entrada1`..`entrada4`). It takes four raw, asynchronous, active-high push-button lines and produces one status byte per button:

- debounced level;
- sticky press and release flags;
- saturating press count.

The program polls these bytes through its input-port instructions and clears them by writing a 4-bit clear mask from an output port.

## Interface

Parameters:
- `DEB_CYCLES`, default 50000: consecutive cycles a synchronized input must differ from the stable level before the change is accepted. Must be ≥ 2.
- `CW`, default 16: debounce counter width. Must satisfy 2^CW > DEB_CYCLES.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `btn`  in  4  raw button lines, asynchronous, 1 = pressed. `btn[i]` maps to `entrada(i+1)`.
- `clr`  in  4  synchronous clear request per button, level-sensitive, sampled every rising edge.
- `entrada1`  out  8  status byte for button 0.
- `entrada2`  out  8  status byte for button 1.
- `entrada3`  out  8  status byte for button 2.
- `entrada4`  out  8  status byte for button 3.

## Operation

Status byte layout, identical for all four buttons: `{cnt[3:0], 1'b0, rel, prs, lvl}`.
- `lvl`: debounced stable level.
- `prs`: sticky flag, set on an accepted 0→1 transition.
- `rel`: sticky flag, set on an accepted 1→0 transition.
- `cnt`: accepted presses since the last clear, saturating at 15.

Each button channel is independent:
- **Synchronizer:** 2-flop, `s1 <= btn[i]`, `s2 <= s1`.
- **Debounce counter `dc` (CW bits):**
  - if `s2 == lvl`: `dc <= 0`;
  - else if `dc == DEB_CYCLES-1`: `lvl <= s2`, `dc <= 0`, accept event;
  - else: `dc <= dc + 1`.
- **Glitch rejection:** any return of `s2` to `lvl` before acceptance zeroes `dc`. A pulse shorter than DEB_CYCLES synchronized cycles produces no change.
- **Accepted rise:** `prs <= 1`, `cnt <= (cnt == 15) ? 15 : cnt + 1`.
- **Accepted fall:** `rel <= 1`. `cnt` is unchanged.
- **Clear (`clr[i] == 1`):** `prs`, `rel` and `cnt` are cleared. `lvl` and `dc` are unaffected.
- **Clear and accepted event on the same edge:** the event wins and is counted after the clear.
  - Rise: `prs = 1`, `rel = 0`, `cnt = 1`.
  - Fall: `rel = 1`, `prs = 0`, `cnt = 0`.
- **Clear held high for several cycles:** flags stay cleared, except that an event on any of those edges is still recorded per the rule above.
- **Outputs:** the `entrada` bytes are driven directly from channel registers, with no combinational path from `btn` or `clr`. Bit 3 is constant 0.

## Timing

- **Reset:** asserting `reset` low immediately forces all state to 0: `s1`, `s2`, `dc`, `lvl`, `prs`, `rel`, `cnt`. All four `entrada` bytes read 8'h00 with no clock needed. Reset asserted mid-debounce discards the partial count.
- **Reset release:** synchronous use begins at the first rising edge with `reset` high. A button held during reset is accepted as a press after the normal latency.
- **Acceptance latency:** `btn[i]` changes before edge E1 and stays constant. Then:
  - `s2` reflects the change at E2;
  - `dc` counts 1..DEB_CYCLES-1 on edges E3..E(DEB_CYCLES+1);
  - `lvl`, `prs`/`rel` and `cnt` update together at edge E(DEB_CYCLES+2).
- **Downstream:** the CPU registers each `entrada` byte once more before the register file. Software sees the change one cycle after the update above.
- **Clear latency:** a clear applied at edge C shows in the outputs after edge C.
- **Clear width:** a 1-cycle `clr` pulse is sufficient.

## Test plan

All scenarios use DEB_CYCLES=4, CW=3.

1. **Reset:** hold `reset`=0 with `btn`=4'hF and clock running → all `entrada` = 8'h00. Release reset, keep `btn[0]`=1 → `entrada1` = 8'h13 at edge 6 after release; other buttons similarly.
2. **Latency and glitch:** raise `btn[1]`=1 → `entrada2` = 8'h00 through edge 5, 8'h13 at edge 6. Separately, a 3-cycle pulse on `btn[2]` → `entrada3` stays 8'h00.
3. **Release and saturation:**
   - release `btn[1]` → `entrada2` = 8'h16 six edges later;
   - 16 further clean press/release pairs → `cnt` saturates, `entrada2` = 8'hF6 after the final release;
   - a 17th press → `entrada2` = 8'hF7 (still saturated).
4. **Clear:** with `entrada1` = 8'h16, pulse `clr[0]` for 1 cycle → `entrada1` = 8'h00 after that edge; `lvl` is unaffected.
5. **Clear/event collision:** assert `clr[3]` on exactly the edge where a `btn[3]` rise is accepted, starting from `cnt`=5 → `entrada4` = 8'h13. Fall collision → 8'h04.
6. **Reset mid-debounce and independence:**
   - pull `reset` low while `dc`=2 → outputs 0 immediately; after release the channel needs the full latency again;
   - concurrent activity on all four buttons produces independent, correct bytes.

Source files
------------

// File: rtl/entrada_pulsadores.sv
// ============================================================================
// entrada_pulsadores: four-channel push-button synchronizer/debouncer with
// sticky press/release flags and saturating press counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module entrada_pulsadores #(
    parameter int DEB_CYCLES = 50000,
    parameter int CW         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [3:0] clr,
    output logic [7:0] entrada1,
    output logic [7:0] entrada2,
    output logic [7:0] entrada3,
    output logic [7:0] entrada4
);

    localparam logic [CW-1:0] C_DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [3:0]    C_CNT_MAX  = 4'hF;

    logic [7:0] status [4];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_ch
            logic          s1_q, s1_d;
            logic          s2_q, s2_d;
            logic          lvl_q, lvl_d;
            logic          prs_q, prs_d;
            logic          rel_q, rel_d;
            logic [CW-1:0] dc_q, dc_d;
            logic [3:0]    cnt_q, cnt_d;
            logic [3:0]    cnt_base;

            always_comb begin
                s1_d     = btn[i];
                s2_d     = s1_q;
                lvl_d    = lvl_q;
                dc_d     = dc_q;
                // Clear is applied first so an event on the same edge still lands.
                prs_d    = clr[i] ? 1'b0 : prs_q;
                rel_d    = clr[i] ? 1'b0 : rel_q;
                cnt_base = clr[i] ? 4'd0 : cnt_q;
                cnt_d    = cnt_base;

                if (s2_q == lvl_q) begin
                    dc_d = '0;
                end else if (dc_q == C_DEB_LAST) begin
                    lvl_d = s2_q;
                    dc_d  = '0;
                    if (s2_q) begin
                        prs_d = 1'b1;
                        if (cnt_base != C_CNT_MAX) begin
                            cnt_d = cnt_base + 4'd1;
                        end
                    end else begin
                        rel_d = 1'b1;
                    end
                end else begin
                    dc_d = dc_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s1_q  <= 1'b0;
                    s2_q  <= 1'b0;
                    lvl_q <= 1'b0;
                    prs_q <= 1'b0;
                    rel_q <= 1'b0;
                    dc_q  <= '0;
                    cnt_q <= 4'd0;
                end else begin
                    s1_q  <= s1_d;
                    s2_q  <= s2_d;
                    lvl_q <= lvl_d;
                    prs_q <= prs_d;
                    rel_q <= rel_d;
                    dc_q  <= dc_d;
                    cnt_q <= cnt_d;
                end
            end

            assign status[i] = {cnt_q, 1'b0, rel_q, prs_q, lvl_q};
        end
    endgenerate

    assign entrada1 = status[0];
    assign entrada2 = status[1];
    assign entrada3 = status[2];
    assign entrada4 = status[3];

endmodule

`default_nettype wire

// File: tb/tb_entrada_pulsadores.sv
// ============================================================================
// tb_entrada_pulsadores: directed vectors for entrada_pulsadores (DEB_CYCLES=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_entrada_pulsadores;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] clr;
    logic [7:0] entrada1, entrada2, entrada3, entrada4;

    int total = 0;
    int bad   = 0;

    entrada_pulsadores #(
        .DEB_CYCLES(4),
        .CW        (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .clr     (clr),
        .entrada1(entrada1),
        .entrada2(entrada2),
        .entrada3(entrada3),
        .entrada4(entrada4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] b;
        logic [3:0] c;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
        logic [7:0] e4;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [3:0] b, input logic [3:0] c,
                       input logic [7:0] e1, input logic [7:0] e2,
                       input logic [7:0] e3, input logic [7:0] e4);
        vec_t v;
        v.b = b; v.c = c; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
        vt.push_back(v);
    endtask

    task automatic add_n(input int n, input logic [3:0] b, input logic [3:0] c,
                         input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input logic [7:0] e4);
        for (int k = 0; k < n; k++) add(b, c, e1, e2, e3, e4);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [7:0] e4);
        check({name, ".entrada1"}, entrada1, e1);
        check({name, ".entrada2"}, entrada2, e2);
        check({name, ".entrada3"}, entrada3, e3);
        check({name, ".entrada4"}, entrada4, e4);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            btn = vt[i].b;
            clr = vt[i].c;
            tick(1);
            check_all($sformatf("vec%0d", i), vt[i].e1, vt[i].e2, vt[i].e3, vt[i].e4);
        end
    endtask

    task automatic pulse_btn(input int ch);
        btn[ch] = 1'b1;
        tick(6);
        btn[ch] = 1'b0;
        tick(6);
    endtask

    int         a_lo, a_hi, b_lo, b_hi, c_lo, c_hi;
    logic [3:0] ecnt;

    initial begin
        reset = 1'b0;
        btn   = 4'hF;
        clr   = 4'h0;

        // A: btn[1] rise with concurrent 3-cycle glitch on btn[2], then release
        a_lo = vt.size();
        add_n(3, 4'b0110, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        add_n(2, 4'b0010, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        add_n(3, 4'b0010, 4'b0000, 8'h00, 8'h13, 8'h00, 8'h00);
        add_n(5, 4'b0000, 4'b0000, 8'h00, 8'h13, 8'h00, 8'h00);
        add  (   4'b0000, 4'b0000, 8'h00, 8'h16, 8'h00, 8'h00);
        a_hi = vt.size();

        // B: press/release btn[0], then 1-cycle clear on ch0 (lvl 0) and ch1 (lvl 1)
        b_lo = vt.size();
        add_n(5, 4'b0011, 4'b0000, 8'h00, 8'hF7, 8'h00, 8'h00);
        add  (   4'b0011, 4'b0000, 8'h13, 8'hF7, 8'h00, 8'h00);
        add_n(5, 4'b0010, 4'b0000, 8'h13, 8'hF7, 8'h00, 8'h00);
        add  (   4'b0010, 4'b0000, 8'h16, 8'hF7, 8'h00, 8'h00);
        add  (   4'b0010, 4'b0011, 8'h00, 8'h01, 8'h00, 8'h00);
        add  (   4'b0010, 4'b0000, 8'h00, 8'h01, 8'h00, 8'h00);
        b_hi = vt.size();

        // C: clear colliding with accepted rise (clr held 2 edges), then with fall
        c_lo = vt.size();
        add_n(4, 4'b1010, 4'b0000, 8'h00, 8'h01, 8'h00, 8'h56);
        add  (   4'b1010, 4'b1000, 8'h00, 8'h01, 8'h00, 8'h00);
        add  (   4'b1010, 4'b1000, 8'h00, 8'h01, 8'h00, 8'h13);
        add_n(5, 4'b0010, 4'b0000, 8'h00, 8'h01, 8'h00, 8'h13);
        add  (   4'b0010, 4'b1000, 8'h00, 8'h01, 8'h00, 8'h04);
        add  (   4'b0010, 4'b0000, 8'h00, 8'h01, 8'h00, 8'h04);
        c_hi = vt.size();

        // Reset held with all buttons pressed, then accepted after normal latency
        tick(3);
        check_all("reset_hold", 8'h00, 8'h00, 8'h00, 8'h00);
        reset = 1'b1;
        tick(5);
        check_all("rel_e5", 8'h00, 8'h00, 8'h00, 8'h00);
        tick(1);
        check_all("rel_e6", 8'h13, 8'h13, 8'h13, 8'h13);

        // Asynchronous reset: outputs clear with no clock edge
        reset = 1'b0;
        btn   = 4'h0;
        #1;
        check_all("async_reset", 8'h00, 8'h00, 8'h00, 8'h00);
        tick(1);
        reset = 1'b1;

        run_vecs(a_lo, a_hi);

        // 16 more clean pairs on btn[1]; count saturates at 15
        for (int k = 1; k <= 16; k++) begin
            pulse_btn(1);
            ecnt = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
            check($sformatf("sat%0d", k), entrada2, {ecnt, 4'b0110});
        end
        btn[1] = 1'b1;
        tick(6);
        check("sat_press17", entrada2, 8'hF7);

        run_vecs(b_lo, b_hi);

        // Bring ch3 to cnt=5 before the collision vectors
        for (int k = 0; k < 5; k++) pulse_btn(3);
        check("ch3_cnt5", entrada4, 8'h56);

        run_vecs(c_lo, c_hi);

        // Reset while ch0 debounce count is 2 discards the partial count
        btn = 4'b0011;
        tick(4);
        reset = 1'b0;
        #1;
        check_all("mid_reset", 8'h00, 8'h00, 8'h00, 8'h00);
        tick(2);
        reset = 1'b1;
        tick(5);
        check_all("post_reset_e5", 8'h00, 8'h00, 8'h00, 8'h00);
        tick(1);
        check_all("post_reset_e6", 8'h13, 8'h13, 8'h00, 8'h00);

        // Independent simultaneous releases and presses
        btn = 4'b1100;
        tick(5);
        check_all("indep_e5", 8'h13, 8'h13, 8'h00, 8'h00);
        tick(1);
        check_all("indep_e6", 8'h16, 8'h16, 8'h13, 8'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
